// File: rtl/reg_wb_buffer_if.sv
// Writeback request / register-file write port / pending-query bundle for
// reg_wb_buffer.
//   slave  : the buffer (consumes requests, drives the write port and the
//            pending/forwarding answers)
//   master : the requester/decoder side
// Signals:
//   in_valid/in_ready/in_addr/in_data   writeback request handshake
//   hold                                suppress draining this cycle
//   AD3/WE3/WD3                         registered register-file write port
//   q_addr1/q_addr2                     decode query addresses
//   pend1/pend2                         write pending for the queried address
//   fwd1_data/fwd2_data                 youngest pending value (FWD_BYPASS_EN)
//   count                               occupied FIFO entries
interface reg_wb_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic [ADDR_W-1:0] AD3;
  logic              WE3;
  logic [DATA_W-1:0] WD3;
  logic [ADDR_W-1:0] q_addr1;
  logic [ADDR_W-1:0] q_addr2;
  logic              pend1;
  logic              pend2;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_addr, in_data, hold, q_addr1, q_addr2,
    output in_ready, AD3, WE3, WD3, pend1, pend2, fwd1_data, fwd2_data, count
  );

  modport master (
    output in_valid, in_addr, in_data, hold, q_addr1, q_addr2,
    input  in_ready, AD3, WE3, WD3, pend1, pend2, fwd1_data, fwd2_data, count
  );
endinterface

// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer: writeback-side initiator for the 32x32 register file.
// Buffers (rd, data) writeback requests in an in-order FIFO of DEPTH entries
// and drains one per cycle onto the registered write port AD3/WE3/WD3.
// Writes to x0 are accepted but discarded. Decode can query two addresses
// and learn whether a write to them is still buffered or in flight.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  reg_wb_buffer_if.slave (request handshake, hold, write port,
//        query addresses, pend1/2, fwd1/2_data, count)
//
// Optional feature: define FWD_BYPASS_EN to build forwarding of the youngest
// pending value onto fwd1_data/fwd2_data; otherwise those outputs are 0.
module reg_wb_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ad3;
  logic              we3;
  logic [DATA_W-1:0] wd3;

  logic ready;
  logic push;
  logic pop;

  // Readiness depends only on occupancy, never on a same-cycle pop.
  assign ready = (cnt < CNT_W'(DEPTH));
  assign push  = bus.in_valid && ready && (bus.in_addr != '0);
  assign pop   = (cnt != '0) && !bus.hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ad3    <= '0;
      we3    <= 1'b0;
      wd3    <= '0;
    end else begin
      we3 <= 1'b0;
      // pop and push never target the same slot: pop needs cnt>0, push
      // needs cnt<DEPTH, and the pointers only coincide at 0 or DEPTH.
      if (pop) begin
        we3         <= 1'b1;
        ad3         <= mem_addr[rd_ptr];
        wd3         <= mem_data[rd_ptr];
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem_addr[wr_ptr] <= bus.in_addr;
        mem_data[wr_ptr] <= bus.in_data;
        vld[wr_ptr]      <= 1'b1;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.AD3      = ad3;
  assign bus.WE3      = we3;
  assign bus.WD3      = wd3;
  assign bus.count    = cnt;

`ifdef FWD_BYPASS_EN
  logic              pend1_c, pend2_c;
  logic [DATA_W-1:0] fwd1_c,  fwd2_c;

  // Scan from the in-flight register, then oldest to newest FIFO entry;
  // each later hit overrides, so the youngest matching write wins.
  always_comb begin
    pend1_c = 1'b0;
    pend2_c = 1'b0;
    fwd1_c  = '0;
    fwd2_c  = '0;
    if (we3 && (ad3 == bus.q_addr1)) begin
      pend1_c = 1'b1;
      fwd1_c  = wd3;
    end
    if (we3 && (ad3 == bus.q_addr2)) begin
      pend2_c = 1'b1;
      fwd2_c  = wd3;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (vld[rd_ptr + PTR_W'(k)] && (mem_addr[rd_ptr + PTR_W'(k)] == bus.q_addr1)) begin
        pend1_c = 1'b1;
        fwd1_c  = mem_data[rd_ptr + PTR_W'(k)];
      end
      if (vld[rd_ptr + PTR_W'(k)] && (mem_addr[rd_ptr + PTR_W'(k)] == bus.q_addr2)) begin
        pend2_c = 1'b1;
        fwd2_c  = mem_data[rd_ptr + PTR_W'(k)];
      end
    end
    if (bus.q_addr1 == '0) begin
      pend1_c = 1'b0;
      fwd1_c  = '0;
    end
    if (bus.q_addr2 == '0) begin
      pend2_c = 1'b0;
      fwd2_c  = '0;
    end
  end

  assign bus.pend1     = pend1_c;
  assign bus.pend2     = pend2_c;
  assign bus.fwd1_data = fwd1_c;
  assign bus.fwd2_data = fwd2_c;
`else
  logic pend1_c, pend2_c;

  always_comb begin
    pend1_c = we3 && (ad3 == bus.q_addr1);
    pend2_c = we3 && (ad3 == bus.q_addr2);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pend1_c = pend1_c || (vld[k] && (mem_addr[k] == bus.q_addr1));
      pend2_c = pend2_c || (vld[k] && (mem_addr[k] == bus.q_addr2));
    end
    if (bus.q_addr1 == '0) pend1_c = 1'b0;
    if (bus.q_addr2 == '0) pend2_c = 1'b0;
  end

  assign bus.pend1     = pend1_c;
  assign bus.pend2     = pend2_c;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Bench for reg_wb_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the buffer.
module tb_reg_wb_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Reference model: queue of pending writes plus the write-port register.
  wr_t               mq[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_ad;
  logic [DATA_W-1:0] m_wd;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_ad = '0;
    m_wd = '0;
  endtask

  // One rising edge of the model, evaluated from the inputs and the
  // pre-edge queue content.
  task automatic model_edge();
    bit ready;
    bit do_pop;
    wr_t e;
    ready  = (mq.size() < DEPTH);
    do_pop = (mq.size() > 0) && !bus.hold;
    if (do_pop) begin
      e    = mq.pop_front();
      m_we = 1'b1;
      m_ad = e.addr;
      m_wd = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (bus.in_valid && ready && bus.in_addr != 0) begin
      e.addr = bus.in_addr;
      e.data = bus.in_data;
      mq.push_back(e);
    end
  endtask

  function automatic bit model_pend(input logic [ADDR_W-1:0] q);
    if (q == 0) return 1'b0;
    if (m_we && m_ad == q) return 1'b1;
    foreach (mq[i]) if (mq[i].addr == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] model_fwd(input logic [ADDR_W-1:0] q);
    logic [DATA_W-1:0] v;
    v = '0;
`ifdef FWD_BYPASS_EN
    if (q != 0) begin
      if (m_we && m_ad == q) v = m_wd;
      foreach (mq[i]) if (mq[i].addr == q) v = mq[i].data;
    end
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},    32'(bus.count),    32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".WE3"},      32'(bus.WE3),      32'(m_we));
    chk({tag, ".AD3"},      32'(bus.AD3),      32'(m_ad));
    chk({tag, ".WD3"},      bus.WD3,           m_wd);
    chk({tag, ".pend1"},    32'(bus.pend1),    32'(model_pend(bus.q_addr1)));
    chk({tag, ".pend2"},    32'(bus.pend2),    32'(model_pend(bus.q_addr2)));
    chk({tag, ".fwd1"},     bus.fwd1_data,     model_fwd(bus.q_addr1));
    chk({tag, ".fwd2"},     bus.fwd2_data,     model_fwd(bus.q_addr2));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic req(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.hold     = 1'b0;
    bus.q_addr1  = '0;
    bus.q_addr2  = '0;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("post_reset");

    // Single write, one-cycle latency, one-cycle pulse
    req(1'b1, 5'd10, 32'hDEAD_BEEF);
    tick("single_acc");
    chk("single_cnt1", 32'(bus.count), 32'd1);
    req(1'b0, '0, '0);
    tick("single_we");
    chk("single_we_hi", 32'(bus.WE3), 32'd1);
    chk("single_ad", 32'(bus.AD3), 32'd10);
    chk("single_wd", bus.WD3, 32'hDEAD_BEEF);
    chk("single_cnt0", 32'(bus.count), 32'd0);
    tick("single_end");
    chk("single_we_lo", 32'(bus.WE3), 32'd0);

    // Fill while held, reject a fifth request, then drain back to back
    bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, ADDR_W'(i), 32'(i * 32'h111));
      tick("fill");
    end
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    req(1'b1, 5'd6, 32'h6666);
    tick("full_reject");
    chk("full_cnt", 32'(bus.count), 32'd4);
    req(1'b0, '0, '0);
    tick("hold_keep");
    bus.hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick("drain");
      chk("drain_ad", 32'(bus.AD3), 32'(i));
      chk("drain_we", 32'(bus.WE3), 32'd1);
    end
    tick("drain_end");

    // x0 request is consumed but never written
    req(1'b1, 5'd0, 32'h1234);
    tick("x0_acc");
    chk("x0_cnt", 32'(bus.count), 32'd0);
    req(1'b1, 5'd5, 32'h55);
    tick("x5_acc");
    req(1'b0, '0, '0);
    tick("x5_we");
    chk("x5_wd", bus.WD3, 32'h55);
    tick("x5_end");

    // Same-rd ordering and forwarding of the youngest value
    bus.hold = 1'b1;
    bus.q_addr1 = 5'd7;
    req(1'b1, 5'd7, 32'h1);
    tick("x7a");
    req(1'b1, 5'd7, 32'h2);
    tick("x7b");
    req(1'b0, '0, '0);
    chk("x7_pend1", 32'(bus.pend1), 32'd1);
    bus.hold = 1'b0;
    tick("x7_d1");
    chk("x7_wd1", bus.WD3, 32'h1);
    tick("x7_d2");
    chk("x7_wd2", bus.WD3, 32'h2);
    tick("x7_end");
    bus.q_addr1 = '0;

    // Pending on the in-flight write only
    bus.q_addr2 = 5'd9;
    req(1'b1, 5'd9, 32'h99);
    tick("x9_acc");
    req(1'b0, '0, '0);
    tick("x9_we");
    chk("x9_pend2", 32'(bus.pend2), 32'd1);
    tick("x9_gone");
    chk("x9_pend2_lo", 32'(bus.pend2), 32'd0);
    bus.q_addr2 = '0;

    // Asynchronous reset during a drain
    bus.hold = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      req(1'b1, ADDR_W'(i), 32'(i));
      tick("pre_rst_fill");
    end
    req(1'b0, '0, '0);
    bus.hold = 1'b0;
    tick("pre_rst_drain");
    chk("pre_rst_cnt", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("post_rst");
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      req(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom);
      bus.hold    = ($urandom_range(0, 9) < 3);
      bus.q_addr1 = ADDR_W'($urandom_range(0, 7));
      bus.q_addr2 = ADDR_W'($urandom_range(0, 7));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_buffer.md
Name: reg_wb_buffer

Overview:
- Writeback-side initiator for the CPU's 32x32 register file.
- Accepts writeback requests (rd, data) from the execute/load paths over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one request per cycle into the register file's write port (AD3/WE3/WD3) through registered outputs.
- Reports pending writes per read address so decode can stall, or forward when the optional feature is on.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  writeback request valid.
- in_ready  output  1  buffer can accept a request this cycle.
- in_addr  input  ADDR_W  destination register rd.
- in_data  input  DATA_W  value to write.
- hold  input  1  suppress draining this cycle (register file port in use elsewhere).
- AD3  output  ADDR_W  register file write address.
- WE3  output  1  register file write enable.
- WD3  output  DATA_W  register file write data.
- q_addr1  input  ADDR_W  query address, decode source 1.
- q_addr2  input  ADDR_W  query address, decode source 2.
- pend1  output  1  write to q_addr1 buffered or in flight.
- pend2  output  1  write to q_addr2 buffered or in flight.
- fwd1_data  output  DATA_W  youngest pending value for q_addr1 (FWD_BYPASS_EN only).
- fwd2_data  output  DATA_W  youngest pending value for q_addr2 (FWD_BYPASS_EN only).
- count  output  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (async, rst=1): FIFO emptied, pointers 0, count=0; WE3=0, AD3=0, WD3=0; pend1/2=0, fwd1/2_data=0. in_ready=1 once rst is deasserted.
- Accept: on a rising edge with in_valid && in_ready. in_ready = (count < DEPTH); it does not depend on a same-cycle pop.
- x0 filter: an accepted request with in_addr==0 is consumed (handshake completes) but is never enqueued. count is unchanged and no WE3 is generated.
- Drain: each rising edge with count>0 and hold=0 pops the head into the output registers: WE3<=1, AD3<=head addr, WD3<=head data. Otherwise WE3<=0, and AD3/WD3 hold their last values.
- WE3 is a one-cycle pulse per entry; back-to-back entries give consecutive pulses.
- Latency: a request accepted into an empty buffer with hold=0 appears on WE3 exactly 1 cycle after acceptance. Steady-state throughput is 1 per cycle.
- Ordering: strict FIFO. Two writes to the same rd retire in acceptance order, so the last accepted value wins in the register file.
- Simultaneous push and pop: allowed whenever count<DEPTH; count stays the same.
- Full: count==DEPTH forces in_ready=0 even if a pop occurs that cycle; in_ready returns to 1 the cycle after the pop.
- Pointers wrap modulo DEPTH. count saturates neither above DEPTH nor below 0.
- hold asserted while full: the buffer stalls with no loss; contents are preserved indefinitely.
- Pending (combinational from state and query inputs):
  - pendN=1 if any valid FIFO entry has addr==q_addrN, or if WE3=1 && AD3==q_addrN (in-flight write lands this edge).
  - pendN=0 when q_addrN==0.
- Reset mid-operation: all buffered and in-flight writes are discarded. WE3 drops to 0 asynchronously.

Optional Feature:
- Macro: FWD_BYPASS_EN.
- Defined: fwdN_data is combinationally the data of the youngest match for q_addrN. Priority: newest FIFO entry, then older FIFO entries, then the in-flight output register. The value is 0 when pendN=0. Decode may bypass instead of stalling.
- Undefined: fwd1_data and fwd2_data are tied to 0 and no comparison/priority logic is built. pend1/pend2 are unchanged.

Test Plan:
- Reset then single write: in_addr=10, in_data=0xDEADBEEF, hold=0 -> next cycle WE3=1, AD3=10, WD3=0xDEADBEEF for exactly 1 cycle; count 1->0.
- Fill with hold=1: 4 writes to x1..x4 -> count=4, in_ready=0, a 5th request is not accepted. Release hold -> WE3 pulses 4 consecutive cycles, AD3=1,2,3,4.
- x0 drop: write x0=0x1234 then x5=0x55 -> only one WE3 pulse (AD3=5, WD3=0x55); count never exceeds 1.
- Same-rd ordering: x7=0x1 then x7=0x2 with hold=1, q_addr1=7 -> pend1=1; with FWD_BYPASS_EN, fwd1_data=0x2. Release hold -> WD3 sequence 0x1, 0x2.
- Pending on in-flight: the cycle WE3=1 with AD3=9 and q_addr2=9 -> pend2=1; the next cycle with an empty FIFO -> pend2=0.
- Async reset mid-drain: assert rst while count=3 and WE3=1 -> WE3=0 and count=0 immediately. No further WE3 pulses after rst deasserts.
